// File: rtl/sprite_dbuf_pkg.sv
// Register map and shared types for the double-buffered sprite store.
package sprite_dbuf_pkg;

   localparam logic [31:0] BASE_SPRITE = 32'h0030_0000;

   localparam logic [3:0] SPR_CTRL   = 4'h0;
   localparam logic [3:0] SPR_WPTR   = 4'h4;
   localparam logic [3:0] SPR_WDATA  = 4'h8;
   localparam logic [3:0] SPR_STATUS = 4'hC;

   localparam int SPR_CTRL_SWAP     = 0;
   localparam int SPR_CTRL_WPTR_CLR = 1;

   typedef enum logic [1:0] {
      REG_CTRL   = SPR_CTRL[3:2],
      REG_WPTR   = SPR_WPTR[3:2],
      REG_WDATA  = SPR_WDATA[3:2],
      REG_STATUS = SPR_STATUS[3:2]
   } spr_reg_e;

   function automatic logic spr_hit(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:4] == base[31:4];
   endfunction

   function automatic spr_reg_e spr_reg_of(input logic [1:0] word_off);
      return spr_reg_e'(word_off);
   endfunction

endpackage

// File: rtl/sprite_dbuf_if.sv
// Register bus seen by the sprite store: byte address, write strobe, read-back.
interface sprite_dbuf_if;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_wen;
   logic [31:0] bus_rdata;

   modport master (output bus_addr, output bus_wdata, output bus_wen, input  bus_rdata);
   modport slave  (input  bus_addr, input  bus_wdata, input  bus_wen, output bus_rdata);
endinterface

// File: rtl/sprite_bank_ram.sv
// Simple dual-port pixel RAM holding both banks; MSB of each address picks the bank.
module sprite_bank_ram #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 18
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge clk_50mhz) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Only the output latch is reset, which maps onto the RAM's own output-register reset.
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sprite_dbuf.sv
// Double-buffered sprite store: MCU fills the back bank over the register bus,
// display reads the front bank; bank swaps land only on frame_start.
module sprite_dbuf
   import sprite_dbuf_pkg::*;
#(
   parameter int          IDX_W = 14,
   parameter int          PIX_W = 18,
   parameter logic [31:0] BASE  = BASE_SPRITE
) (
   input  logic             clk_50mhz,
   input  logic             rst,
   sprite_dbuf_if.slave     sbus,
   input  logic             frame_start,
   input  logic [IDX_W-1:0] pix_rd_idx,
   output logic [PIX_W-1:0] pix_rd_data,
   output logic             front_bank
);

   localparam int ADDR_W = IDX_W + 1;

   logic             r_front_bank;
   logic             r_swap_pending;
   logic [IDX_W-1:0] r_wptr;

   logic             w_front_bank_next;
   logic             w_swap_pending_next;
   logic [IDX_W-1:0] w_wptr_next;

   logic             w_sel;
   spr_reg_e         w_reg;
   logic             w_ctrl_wr;
   logic             w_wptr_wr;
   logic             w_wdata_wr;
   logic             w_swap;
   logic             w_unused_bits;

   assign w_sel      = spr_hit(sbus.bus_addr, BASE);
   assign w_reg      = spr_reg_of(sbus.bus_addr[3:2]);
   assign w_ctrl_wr  = sbus.bus_wen && w_sel && (w_reg == REG_CTRL);
   assign w_wptr_wr  = sbus.bus_wen && w_sel && (w_reg == REG_WPTR);
   assign w_wdata_wr = sbus.bus_wen && w_sel && (w_reg == REG_WDATA);
   assign w_swap     = frame_start && r_swap_pending;

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_front_bank   <= 1'b0;
         r_swap_pending <= 1'b0;
         r_wptr         <= '0;
      end else begin
         r_front_bank   <= w_front_bank_next;
         r_swap_pending <= w_swap_pending_next;
         r_wptr         <= w_wptr_next;
      end
   end

   // A request raised on a frame_start cycle only arms the swap; it fires on the next frame.
   always_comb begin
      w_front_bank_next   = r_front_bank;
      w_swap_pending_next = r_swap_pending;
      w_wptr_next         = r_wptr;

      if (w_swap) begin
         w_front_bank_next   = ~r_front_bank;
         w_swap_pending_next = 1'b0;
      end else if (w_ctrl_wr && sbus.bus_wdata[SPR_CTRL_SWAP]) begin
         w_swap_pending_next = 1'b1;
      end

      if (w_ctrl_wr && sbus.bus_wdata[SPR_CTRL_WPTR_CLR]) begin
         w_wptr_next = '0;
      end else if (w_wptr_wr) begin
         w_wptr_next = sbus.bus_wdata[IDX_W-1:0];
      end else if (w_wdata_wr) begin
         w_wptr_next = r_wptr + 1'b1;
      end
   end

   always_comb begin
      sbus.bus_rdata = '0;
      if (w_sel) begin
         case (w_reg)
            REG_WPTR:   sbus.bus_rdata = 32'(r_wptr);
            REG_STATUS: sbus.bus_rdata = {30'b0, r_swap_pending, r_front_bank};
            default:    sbus.bus_rdata = '0;
         endcase
      end
   end

   // Writes always target the bank not on screen, using the pre-toggle bank on a swap cycle.
   sprite_bank_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (PIX_W)
   ) u_bank_ram (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .i_wr_en   (w_wdata_wr),
      .i_wr_addr ({~r_front_bank, r_wptr}),
      .i_wr_data (sbus.bus_wdata[PIX_W-1:0]),
      .i_rd_addr ({r_front_bank, pix_rd_idx}),
      .o_rd_data (pix_rd_data)
   );

   assign front_bank    = r_front_bank;
   assign w_unused_bits = ^{sbus.bus_addr[1:0], sbus.bus_wdata[31:PIX_W]};

endmodule
